// File: rtl/key_char_fifo.sv
// key_char_fifo: translates PS/2 set-2 make codes to ASCII with Shift/Caps Lock handling
// and queues the characters in a first-word-fall-through FIFO.
module key_char_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [511:0]          key_down,
    input  logic [8:0]            last_change,
    input  logic                  key_valid,
    input  logic                  rd_en,
    input  logic                  clear,
    output logic [7:0]            rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  caps_lock
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            mem_q [DEPTH];
    logic [7:0]            mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  caps_lock_q, caps_lock_d;
    logic                  caps_held_q, caps_held_d;

    logic [7:0] code, lower, char_w;
    logic       ev, make, shift, is_caps, mapped, is_letter;
    logic       push_req, push_ok, pop, drop;

    assign code    = last_change[7:0];
    assign ev      = key_valid & ~last_change[8];
    assign make    = key_down[last_change];
    assign shift   = key_down[9'h012] | key_down[9'h059];
    assign is_caps = code == 8'h58;

    // Lowercase/unshifted ASCII for each mapped key; 0 marks an unmapped code.
    always_comb begin
        lower = 8'h00;
        case (code)
            8'h1C: lower = 8'h61;
            8'h32: lower = 8'h62;
            8'h21: lower = 8'h63;
            8'h23: lower = 8'h64;
            8'h24: lower = 8'h65;
            8'h2B: lower = 8'h66;
            8'h34: lower = 8'h67;
            8'h33: lower = 8'h68;
            8'h43: lower = 8'h69;
            8'h3B: lower = 8'h6A;
            8'h42: lower = 8'h6B;
            8'h4B: lower = 8'h6C;
            8'h3A: lower = 8'h6D;
            8'h31: lower = 8'h6E;
            8'h44: lower = 8'h6F;
            8'h4D: lower = 8'h70;
            8'h15: lower = 8'h71;
            8'h2D: lower = 8'h72;
            8'h1B: lower = 8'h73;
            8'h2C: lower = 8'h74;
            8'h3C: lower = 8'h75;
            8'h2A: lower = 8'h76;
            8'h1D: lower = 8'h77;
            8'h22: lower = 8'h78;
            8'h35: lower = 8'h79;
            8'h1A: lower = 8'h7A;
            8'h45: lower = 8'h30;
            8'h16: lower = 8'h31;
            8'h1E: lower = 8'h32;
            8'h26: lower = 8'h33;
            8'h25: lower = 8'h34;
            8'h2E: lower = 8'h35;
            8'h36: lower = 8'h36;
            8'h3D: lower = 8'h37;
            8'h3E: lower = 8'h38;
            8'h46: lower = 8'h39;
            8'h29: lower = 8'h20;
            8'h5A: lower = 8'h0D;
            8'h66: lower = 8'h08;
            default: lower = 8'h00;
        endcase
    end

    assign mapped    = lower != 8'h00;
    assign is_letter = lower >= 8'h61 && lower <= 8'h7A;
    assign char_w    = (is_letter && (shift ^ caps_lock_q)) ? lower - 8'h20 : lower;

    assign empty    = count_q == '0;
    assign full     = count_q == FULL_CNT;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign caps_lock = caps_lock_q;
    assign rd_data  = empty ? 8'h00 : mem_q[rd_ptr_q];

    assign push_req = ev & make & mapped & ~clear;
    assign pop      = rd_en & ~empty & ~clear;
    assign push_ok  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_comb begin
        mem_d = mem_q;
        if (push_ok) mem_d[wr_ptr_q] = char_w;
        wr_ptr_d    = clear ? '0 : wr_ptr_q + DEPTH_LOG2'(push_ok);
        rd_ptr_d    = clear ? '0 : rd_ptr_q + DEPTH_LOG2'(pop);
        count_d     = clear ? '0 :
                      (push_ok && !pop) ? count_q + 1'b1 :
                      (!push_ok && pop) ? count_q - 1'b1 : count_q;
        overflow_d  = clear ? 1'b0 : overflow_q | drop;
        // Typematic repeats arrive as makes while held; only the first one toggles.
        caps_lock_d = (ev && is_caps && make && !caps_held_q) ? ~caps_lock_q : caps_lock_q;
        caps_held_d = (ev && is_caps) ? make : caps_held_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            caps_lock_q <= 1'b0;
            caps_held_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            caps_lock_q <= caps_lock_d;
            caps_held_q <= caps_held_d;
        end
    end
endmodule
